weight_load_controller: RTL and testbench

Sequences loading of one convolution kernel into the parallel weight register. Accepts N weight words one at a time over a valid/ready stream, assembles them into an N*DATA_WIDTH word, and issues a single-cycle `write` to the weight register only while the convolver is idle. This keeps the kernel from changing mid-window. It sits between the host/DMA weight stream and the weight register inside the convolver.

---
 rtl/weight_ctrl_pkg.sv | 30 +++
 rtl/weight_assembly_buffer.sv | 38 +++
 rtl/weight_load_controller.sv | 110 +++++++++++
 tb/tb_weight_load_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_ctrl_pkg.sv
// Shared definitions for the kernel weight loader: state encoding, sizing defaults
// and the ceiling-log2 helper used to size the word counter.
package weight_ctrl_pkg;

   localparam int unsigned N_DEFAULT          = 25;
   localparam int unsigned DATA_WIDTH_DEFAULT = 16;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_LOAD_ENC   = 2'd1;
   localparam logic [1:0] ST_ARM_ENC    = 2'd2;
   localparam logic [1:0] ST_COMMIT_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_LOAD   = ST_LOAD_ENC,
      ST_ARM    = ST_ARM_ENC,
      ST_COMMIT = ST_COMMIT_ENC
   } state_t;

   // Ceiling log2, never below 1 so the result is always a usable width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return (result == 0) ? 1 : result;
   endfunction

endpackage

// File: rtl/weight_assembly_buffer.sv
// N-slot indexed write buffer that assembles weight words into one wide kernel bus.
// Slot 0 occupies the LSBs; clear zeroes all slots before a same-cycle slot write.
module weight_assembly_buffer
   import weight_ctrl_pkg::*;
#(
   parameter int unsigned N          = N_DEFAULT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int unsigned ADDR_WIDTH = clog2(N_DEFAULT + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clear,
   input  logic                    i_wr_en,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_data,
   output logic [N*DATA_WIDTH-1:0] o_bus
);

   logic [N*DATA_WIDTH-1:0] r_bus;
   logic [N*DATA_WIDTH-1:0] w_next;

   always_comb begin
      w_next = i_clear ? '0 : r_bus;
      if (i_wr_en) begin
         for (int unsigned k = 0; k < N; k++) begin
            if (i_addr == ADDR_WIDTH'(k)) w_next[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_bus <= '0;
      else          r_bus <= w_next;
   end

   assign o_bus = r_bus;

endmodule

// File: rtl/weight_load_controller.sv
// Loads one convolution kernel word by word, then commits it to the weight register
// with a single write strobe once the convolver is between windows.
module weight_load_controller
   import weight_ctrl_pkg::*;
#(
   parameter int unsigned N          = N_DEFAULT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [DATA_WIDTH-1:0]    i_in_data,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic                     i_conv_busy,
   output logic [N*DATA_WIDTH-1:0]  o_weight_write,
   output logic                     o_write,
   output logic                     o_busy,
   output logic                     o_weights_loaded,
   output logic [clog2(N+1)-1:0]    o_word_count
);

   localparam int unsigned WC_WIDTH = clog2(N + 1);

   state_t              r_state;
   logic                r_write;
   logic                r_busy;
   logic                r_loaded;
   logic [WC_WIDTH-1:0] r_word_count;
   logic                w_accept;
   logic                w_clear;

   // Abort wins over a same-cycle accept, so a cancelled word never lands in the buffer.
   assign w_accept = (r_state == ST_LOAD) && i_in_valid && !i_abort;
   // The first word of a load wipes stale slots from any earlier partial kernel.
   assign w_clear  = w_accept && (r_word_count == '0);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_write      <= 1'b0;
         r_busy       <= 1'b0;
         r_loaded     <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_write <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state      <= ST_LOAD;
                  r_busy       <= 1'b1;
                  r_loaded     <= 1'b0;
                  r_word_count <= '0;
               end
            end
            ST_LOAD: begin
               if (i_abort) begin
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_word_count <= '0;
               end else if (i_in_valid) begin
                  r_word_count <= r_word_count + WC_WIDTH'(1);
                  if (r_word_count == WC_WIDTH'(N - 1)) r_state <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (i_abort) begin
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_word_count <= '0;
               end else if (!i_conv_busy) begin
                  r_state <= ST_COMMIT;
                  r_write <= 1'b1;
               end
            end
            ST_COMMIT: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_loaded <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   weight_assembly_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (WC_WIDTH)
   ) u_buffer (
      .i_clk   (i_clock),
      .i_rst_n (i_reset_n),
      .i_clear (w_clear),
      .i_wr_en (w_accept),
      .i_addr  (r_word_count),
      .i_data  (i_in_data),
      .o_bus   (o_weight_write)
   );

   assign o_in_ready       = (r_state == ST_LOAD);
   assign o_write          = r_write;
   assign o_busy           = r_busy;
   assign o_weights_loaded = r_loaded;
   assign o_word_count     = r_word_count;

endmodule

// File: tb/tb_weight_load_controller.sv
// Self-checking bench for weight_load_controller: directed scenarios plus random traffic,
// all compared every cycle against a word-list model of the loader.
module tb_weight_load_controller;

   localparam int N  = 25;
   localparam int DW = 16;
   localparam int CW = 5;
   localparam int BW = N * DW;

   localparam int P_IDLE   = 0;
   localparam int P_LOAD   = 1;
   localparam int P_ARM    = 2;
   localparam int P_COMMIT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic [DW-1:0] i_in_data = '0;
   logic          i_in_valid = 1'b0;
   logic          i_conv_busy = 1'b0;
   logic          o_in_ready;
   logic [BW-1:0] o_weight_write;
   logic          o_write;
   logic          o_busy;
   logic          o_weights_loaded;
   logic [CW-1:0] o_word_count;

   int n_total = 0;
   int n_bad   = 0;

   int          m_phase  = P_IDLE;
   int          m_count  = 0;
   bit          m_loaded = 1'b0;
   int unsigned m_bus[N];
   int unsigned sent[N];
   int          n_writes = 0;

   weight_load_controller #(.N(N), .DATA_WIDTH(DW)) dut (
      .i_clock          (clk),
      .i_reset_n        (rst_n),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .i_in_data        (i_in_data),
      .i_in_valid       (i_in_valid),
      .o_in_ready       (o_in_ready),
      .i_conv_busy      (i_conv_busy),
      .o_weight_write   (o_weight_write),
      .o_write          (o_write),
      .o_busy           (o_busy),
      .o_weights_loaded (o_weights_loaded),
      .o_word_count     (o_word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] pack_model();
      logic [BW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(m_bus[k]);
      return v;
   endfunction

   function automatic logic [BW-1:0] pack_sent();
      logic [BW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(sent[k]);
      return v;
   endfunction

   // Reference model: a load is a list of words filled in order, then a wait for an idle convolver.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  = P_IDLE;
         m_count  = 0;
         m_loaded = 1'b0;
         for (int k = 0; k < N; k++) m_bus[k] = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (i_start) begin
               m_phase  = P_LOAD;
               m_count  = 0;
               m_loaded = 1'b0;
            end
            P_LOAD: if (i_abort) begin
               m_phase = P_IDLE;
               m_count = 0;
            end else if (i_in_valid) begin
               if (m_count == 0) for (int k = 0; k < N; k++) m_bus[k] = 0;
               m_bus[m_count] = int'(i_in_data);
               m_count++;
               if (m_count == N) m_phase = P_ARM;
            end
            P_ARM: if (i_abort) begin
               m_phase = P_IDLE;
               m_count = 0;
            end else if (!i_conv_busy) begin
               m_phase = P_COMMIT;
            end
            default: begin
               m_phase  = P_IDLE;
               m_loaded = 1'b1;
            end
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model, sampled mid-cycle.
   always @(negedge clk) begin
      chk("model_in_ready", BW'(o_in_ready), BW'(m_phase == P_LOAD));
      chk("model_write", BW'(o_write), BW'(m_phase == P_COMMIT));
      chk("model_busy", BW'(o_busy), BW'(m_phase != P_IDLE));
      chk("model_loaded", BW'(o_weights_loaded), BW'(m_loaded));
      chk("model_word_count", BW'(o_word_count), BW'(m_count));
      chk("model_weight_bus", o_weight_write, pack_model());
      if (o_write === 1'b1) n_writes++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Offer words until cnt have been accepted; gapped mode offers on alternate cycles only.
   task automatic stream(input int first, input int cnt, input bit gapped);
      int got = 0;
      int guard = 0;
      bit acc;
      while (got < cnt && guard < 400) begin
         guard++;
         if (!gapped || (guard % 2 == 1)) begin
            i_in_valid = 1'b1;
            i_in_data  = DW'($urandom);
            sent[first + got] = int'(i_in_data);
         end else begin
            i_in_valid = 1'b0;
         end
         acc = i_in_valid && o_in_ready;
         tick();
         if (acc) got++;
      end
      i_in_valid = 1'b0;
      if (got < cnt) chk("stream_timeout", BW'(got), BW'(cnt));
   endtask

   task automatic wait_write(input int limit, output int lat);
      lat = -1;
      for (int i = 0; i < limit; i++) begin
         if (o_write) begin
            lat = i;
            break;
         end
         tick();
      end
      chk("write_seen", BW'(lat >= 0), BW'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, writes, sent_n, lat, w0;
      logic [BW-1:0] snap, exp_bus;

      // Reset held for 100 ns
      #100;
      @(posedge clk);
      #2;
      chk("rst_in_ready", BW'(o_in_ready), BW'(0));
      chk("rst_write", BW'(o_write), BW'(0));
      chk("rst_busy", BW'(o_busy), BW'(0));
      chk("rst_loaded", BW'(o_weights_loaded), BW'(0));
      chk("rst_word_count", BW'(o_word_count), BW'(0));
      chk("rst_weight_bus", o_weight_write, BW'(0));
      rst_n = 1'b1;
      tick();

      // Basic load of words 1..25 with no stalls
      pulse_start();
      chk("basic_in_ready", BW'(o_in_ready), BW'(1));
      first = 0; writes = 0; sent_n = 0;
      for (int c = 1; c <= 40; c++) begin
         i_in_valid = (sent_n < N);
         i_in_data  = DW'(sent_n + 1);
         tick();
         if (i_in_valid) sent_n++;
         if (o_write) begin
            writes++;
            if (first == 0) first = c;
         end
      end
      i_in_valid = 1'b0;
      chk("basic_latency", BW'(first), BW'(26));
      chk("basic_write_count", BW'(writes), BW'(1));
      chk("basic_loaded", BW'(o_weights_loaded), BW'(1));
      chk("basic_word_count", BW'(o_word_count), BW'(25));
      exp_bus = '0;
      for (int k = 0; k < N; k++) exp_bus[k*DW +: DW] = DW'(k + 1);
      chk("basic_slots", o_weight_write, exp_bus);

      // Gapped stream of random words
      pulse_start();
      chk("gap_loaded_cleared", BW'(o_weights_loaded), BW'(0));
      stream(0, N, 1'b1);
      wait_write(10, lat);
      chk("gap_bus", o_weight_write, pack_sent());
      tick();
      chk("gap_loaded", BW'(o_weights_loaded), BW'(1));

      // Convolver busy holds off the commit
      i_conv_busy = 1'b1;
      pulse_start();
      stream(0, N, 1'b0);
      snap = o_weight_write;
      writes = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (o_write) writes++;
      end
      chk("hold_no_write", BW'(writes), BW'(0));
      chk("hold_bus_stable", o_weight_write, snap);
      chk("hold_in_ready", BW'(o_in_ready), BW'(0));
      i_conv_busy = 1'b0;
      tick();
      chk("hold_write_after_fall", BW'(o_write), BW'(1));
      chk("hold_bus", o_weight_write, pack_sent());
      tick();
      chk("hold_write_single", BW'(o_write), BW'(0));
      chk("hold_loaded", BW'(o_weights_loaded), BW'(1));

      // Abort after 12 words, then a start during a later load is ignored
      w0 = n_writes;
      pulse_start();
      stream(0, 12, 1'b0);
      chk("abort_pre_count", BW'(o_word_count), BW'(12));
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_word_count", BW'(o_word_count), BW'(0));
      chk("abort_busy", BW'(o_busy), BW'(0));
      chk("abort_loaded", BW'(o_weights_loaded), BW'(0));
      repeat (5) tick();
      chk("abort_no_write", BW'(n_writes - w0), BW'(0));
      pulse_start();
      stream(0, 5, 1'b0);
      i_start = 1'b1;
      stream(5, 1, 1'b0);
      i_start = 1'b0;
      chk("ignore_start_count", BW'(o_word_count), BW'(6));
      stream(6, N - 6, 1'b0);
      wait_write(10, lat);
      chk("ignore_start_bus", o_weight_write, pack_sent());

      // Abort in ARM beats the commit in the same cycle
      tick();
      i_conv_busy = 1'b1;
      pulse_start();
      stream(0, N, 1'b0);
      w0 = n_writes;
      i_abort = 1'b1;
      i_conv_busy = 1'b0;
      tick();
      i_abort = 1'b0;
      chk("arm_abort_write", BW'(o_write), BW'(0));
      chk("arm_abort_busy", BW'(o_busy), BW'(0));
      tick();
      chk("arm_abort_no_write", BW'(n_writes - w0), BW'(0));

      // Start and abort together in IDLE: start wins
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      chk("start_wins_busy", BW'(o_busy), BW'(1));
      tick();
      i_abort = 1'b0;
      chk("abort_in_load", BW'(o_busy), BW'(0));

      // Reset mid-load discards the partial kernel, then a full reload commits
      pulse_start();
      stream(0, 20, 1'b0);
      w0 = n_writes;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", BW'(o_busy), BW'(0));
      chk("midrst_in_ready", BW'(o_in_ready), BW'(0));
      chk("midrst_count", BW'(o_word_count), BW'(0));
      chk("midrst_bus", o_weight_write, BW'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_no_write", BW'(n_writes - w0), BW'(0));
      pulse_start();
      stream(0, N, 1'b1);
      wait_write(10, lat);
      chk("reload_bus", o_weight_write, pack_sent());

      // Random traffic, checked by the model every cycle
      w0 = n_writes;
      for (int c = 0; c < 4000; c++) begin
         i_start     = ($urandom % 8) == 0;
         i_abort     = ($urandom % 40) == 0;
         i_in_valid  = ($urandom % 3) != 0;
         i_in_data   = DW'($urandom);
         i_conv_busy = ($urandom % 4) == 0;
         tick();
      end
      i_start = 1'b0; i_abort = 1'b0; i_in_valid = 1'b0; i_conv_busy = 1'b0;
      repeat (3) tick();
      chk("random_commits_seen", BW'(n_writes > w0), BW'(1));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
